seg7_scan4: RTL
===============

# seg7_scan4

Four-digit multiplexed 7-segment display driver. It sits directly downstream of a chain of four cascaded 4-bit up/down counters, taking their concatenated nibble outputs as a 16-bit hex value. It scans the digits of a common-anode display at a parameterised rate. Each frame is snapshotted so that all four digits show one coherent count, and leading-zero blanking and per-digit decimal points are optional.

## Interface
- SCAN_DIV, 50000: clk cycles per digit slot; legal range ≥ 4.
- GUARD, 2: cycles at the start of each slot with all anodes off (anti-ghosting); legal range 0 ≤ GUARD < SCAN_DIV.
- clk  in  1  clock; all state changes on the rising edge.
- clr  in  1  reset; asynchronous, active-high.
- dat  in  16  display value: dat[15:12] is digit 3 (leftmost), dat[3:0] is digit 0.
- dpi  in  4  decimal point request per digit, active-high; dpi[i] belongs to digit i.
- blz  in  1  leading-zero blanking enable.
- hold  in  1  freezes the snapshot; the display keeps scanning.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- dp  out  1  decimal point, active-low, registered.
- an  out  4  anode select, active-low, one-hot or all-high, registered.
- frm  out  1  frame-start pulse, active-high.

## Operation
- State:
  - pc is the prescaler, 0..SCAN_DIV-1.
  - idx is the slot index, 2 bits.
  - snap is a 16-bit value register.
  - dsnap is a 4-bit register holding the dpi snapshot.
- Each cycle pc increments. When pc == SCAN_DIV-1, pc goes to 0 and idx increments mod 4 (3 wraps to 0).
- Snapshot load:
  - Trigger: the edge where pc == SCAN_DIV-1, idx == 3 and hold == 0.
  - Action: snap <= dat and dsnap <= dpi.
  - When hold == 1, snap and dsnap keep their values.
- frm = (idx == 0 && pc == 0), decoded from state. It is exactly one cycle wide per frame.
- Leading-zero blanking (blz == 1). A digit is blanked when:
  - digit 3: snap[15:12] == 0;
  - digit 2: snap[15:8] == 0;
  - digit 1: snap[15:4] == 0;
  - digit 0: never blanked.
- With blz == 0, no digit is blanked.
- The dp of a blanked digit is still driven from dsnap. Its anode stays enabled when dsnap[i] == 1 and seg is all off.
- Output decode for the current state, registered at the next edge:
  - pc < GUARD: an = 4'b1111, seg = 7'h7F, dp = 1.
  - Otherwise: an has bit idx low and all other bits high.
  - seg = hex font of snap nibble idx, or 7'h7F if that digit is blanked.
  - dp = ~dsnap[idx].
  - If the digit is blanked and dsnap[idx] == 0, an = 4'b1111.
- Hex font (seg = gfedcba, active-low):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- Reset (clr high):
  - pc = 0, idx = 0, snap = 0, dsnap = 0.
  - an = 4'b1111, seg = 7'h7F, dp = 1.
  - frm reads 1 while in reset because of the state decode.
  - Reset asserted mid-frame aborts the scan immediately. After release, scanning restarts at slot 0, pc 0.

## Timing
- Latency: seg, an and dp reflect the (pc, idx, snap, dsnap) state of the previous cycle (one register stage).
- Frame length: 4·SCAN_DIV cycles. Each anode is active for SCAN_DIV-GUARD cycles per frame.
- Snapshot update:
  - A dat change becomes visible at the first slot-0 output after the next 3→0 wrap.
  - Worst-case delay is 4·SCAN_DIV+1 cycles.
- dat and dpi are sampled only on the snapshot edge. Changes at any other time have no effect, so no tearing within a frame.
- hold is sampled on the snapshot edge only.
- A hold pulse that does not cover that edge has no effect.
- Deasserting hold mid-frame takes effect at the next wrap.
- pc and idx wrap freely and have no terminal state. The block never stalls.

## Test plan
All scenarios use SCAN_DIV = 8 and GUARD = 2.
1. Reset/idle:
   - Stimulus: assert clr for 3 cycles, then release.
   - Required: an = 1111, seg = 7F, dp = 1 during reset and for 2 cycles after release. Then an = 1110 for 6 cycles showing snap = 0 (seg = 40). frm high in the first cycle after release.
2. Snapshot:
   - Stimulus: dat = 16'h12AF, blz = 0.
   - Required: after the next wrap, slots 0..3 show seg 0E, 08, 24, 79 with an 1110, 1101, 1011, 0111 respectively. A dat change mid-frame does not alter the frame in progress.
3. Leading-zero blanking:
   - Stimulus: dat = 16'h0050, blz = 1.
   - Required: digits 3 and 2 have an = 1111. Digit 1 shows 12 and digit 0 shows 40.
   - Stimulus: dat = 16'h0000.
   - Required: only digit 0 is lit, showing 40.
4. Decimal point on a blanked digit:
   - Stimulus: dat = 16'h0007, blz = 1, dpi = 4'b0100.
   - Required: digit 2 slot has an = 1011, seg = 7F, dp = 0. Digit 3 stays off. Digit 0 shows 78 with dp = 1.
5. Hold:
   - Stimulus: hold = 1 across a wrap, then dat changes from 16'h1111 to 16'h2222.
   - Required: the display keeps showing 1111. After hold = 0, 2222 appears at the following frame.
6. Reset mid-scan:
   - Stimulus: assert clr while idx = 2, pc = 5.
   - Required: outputs go blank asynchronously. After release, scan resumes at idx = 0, pc = 0 and snap reads 0.

Source files
------------

// File: rtl/seg7_scan4.sv
// Four-digit multiplexed common-anode 7-segment scanner with per-frame snapshot,
// leading-zero blanking, per-digit decimal points and an anti-ghosting guard band.
module seg7_scan4 #(
   parameter int SCAN_DIV = 50000,
   parameter int GUARD    = 2
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [15:0] dat,
   input  logic [3:0]  dpi,
   input  logic        blz,
   input  logic        hold,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an,
   output logic        frm
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam logic [PW-1:0] PC_LAST  = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0] PC_GUARD = PW'(GUARD);

   logic [PW-1:0] pc_r;
   logic [1:0]    idx_r;
   logic [15:0]   snap_r;
   logic [3:0]    dsnap_r;
   logic          wrap_s;
   logic          load_s;
   logic [3:0]    nib_s;
   logic          blank_s;
   logic [6:0]    seg_s;
   logic          dp_s;
   logic [3:0]    an_s;

   function automatic logic [6:0] hex_font(input logic [3:0] nib);
      logic [6:0] f;
      case (nib)
         4'h0:    f = 7'h40;
         4'h1:    f = 7'h79;
         4'h2:    f = 7'h24;
         4'h3:    f = 7'h30;
         4'h4:    f = 7'h19;
         4'h5:    f = 7'h12;
         4'h6:    f = 7'h02;
         4'h7:    f = 7'h78;
         4'h8:    f = 7'h00;
         4'h9:    f = 7'h10;
         4'hA:    f = 7'h08;
         4'hB:    f = 7'h03;
         4'hC:    f = 7'h46;
         4'hD:    f = 7'h21;
         4'hE:    f = 7'h06;
         4'hF:    f = 7'h0E;
         default: f = 7'h7F;
      endcase
      return f;
   endfunction

   assign wrap_s = (pc_r == PC_LAST);
   assign load_s = wrap_s && (idx_r == 2'd3) && !hold;
   assign frm    = (idx_r == 2'd0) && (pc_r == '0);

   // Prescaler and slot index; both wrap freely.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         pc_r  <= '0;
         idx_r <= 2'd0;
      end else if (wrap_s) begin
         pc_r  <= '0;
         idx_r <= idx_r + 2'd1;
      end else begin
         pc_r  <= pc_r + PW'(1);
         idx_r <= idx_r;
      end
   end

   // Frame snapshot, taken only on the last cycle of slot 3 unless held.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         snap_r  <= 16'h0000;
         dsnap_r <= 4'h0;
      end else if (load_s) begin
         snap_r  <= dat;
         dsnap_r <= dpi;
      end else begin
         snap_r  <= snap_r;
         dsnap_r <= dsnap_r;
      end
   end

   // Current-slot nibble and blanking; a digit blanks only if it and all digits left of it are zero.
   always_comb begin
      nib_s   = 4'h0;
      blank_s = 1'b0;
      case (idx_r)
         2'd0: begin
            nib_s   = snap_r[3:0];
            blank_s = 1'b0;
         end
         2'd1: begin
            nib_s   = snap_r[7:4];
            blank_s = blz && (snap_r[15:4] == 12'h000);
         end
         2'd2: begin
            nib_s   = snap_r[11:8];
            blank_s = blz && (snap_r[15:8] == 8'h00);
         end
         2'd3: begin
            nib_s   = snap_r[15:12];
            blank_s = blz && (snap_r[15:12] == 4'h0);
         end
         default: begin
            nib_s   = 4'h0;
            blank_s = 1'b0;
         end
      endcase
   end

   // Output decode; the anode of a blanked digit stays lit only to show its decimal point.
   always_comb begin
      an_s  = 4'b1111;
      seg_s = 7'h7F;
      dp_s  = 1'b1;
      if (pc_r < PC_GUARD) begin
         an_s  = 4'b1111;
         seg_s = 7'h7F;
         dp_s  = 1'b1;
      end else begin
         an_s  = ~(4'b0001 << idx_r);
         seg_s = blank_s ? 7'h7F : hex_font(nib_s);
         dp_s  = ~dsnap_r[idx_r];
         if (blank_s && !dsnap_r[idx_r]) begin
            an_s = 4'b1111;
         end else begin
            an_s = an_s;
         end
      end
   end

   // Output register stage; reset blanks the display immediately.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         an  <= 4'b1111;
         seg <= 7'h7F;
         dp  <= 1'b1;
      end else begin
         an  <= an_s;
         seg <= seg_s;
         dp  <= dp_s;
      end
   end

endmodule
